// File: rtl/serial_abs_pkg.sv
// Shared definitions for the serial absolute-value converter.
package serial_abs_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Bit counter width: enough to count 0..width-1.
    function automatic int calc_cntw(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_neg_bit.sv
// One-bit serial two's-complement negator cell: s = ~b ^ c, c_next = ~b & c.
module serial_neg_bit (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_b,
    input  logic i_init,
    input  logic i_en,
    output logic o_s
);

    logic r_carry;

    // Carry seeded to 1 at operand load, then rippled one bit per enabled edge.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_carry <= 1'b0;
        else if (i_init)
            r_carry <= 1'b1;
        else if (i_en)
            r_carry <= ~i_b & r_carry;
    end

    assign o_s = ~i_b ^ r_carry;

endmodule

// File: rtl/serial_abs.sv
// Signed-to-sign-magnitude converter; negative operands are negated LSB first.
module serial_abs
    import serial_abs_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [width-1:0] IN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [width-1:0] MAG,
    output logic             SIGN,
    output logic             MINNEG
);

    localparam int cntw = calc_cntw(width);
    localparam logic [cntw-1:0] LAST = cntw'(width - 1);

    state_t            r_state;
    logic [width-1:0]  r_shreg;
    logic [cntw-1:0]   r_cnt;
    logic              w_accept;
    logic              w_neg_init;
    logic              w_shift_en;
    logic              w_bit;

    assign w_accept   = IN_VALID && (r_state == S_IDLE);
    assign w_neg_init = w_accept && IN[width-1];
    assign w_shift_en = (r_state == S_SHIFT);

    assign IN_READY  = (r_state == S_IDLE);
    assign OUT_VALID = (r_state == S_DONE);

    serial_neg_bit u_neg (
        .i_clk  (CLK),
        .i_rst  (RST),
        .i_b    (r_shreg[0]),
        .i_init (w_neg_init),
        .i_en   (w_shift_en),
        .o_s    (w_bit)
    );

    // Control FSM plus operand/result shift registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            MAG     <= '0;
            SIGN    <= 1'b0;
            MINNEG  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!IN[width-1]) begin
                            // Non-negative: magnitude is the operand itself.
                            MAG     <= IN;
                            SIGN    <= 1'b0;
                            MINNEG  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_shreg <= IN;
                            r_cnt   <= '0;
                            SIGN    <= 1'b1;
                            MINNEG  <= (IN[width-2:0] == '0);
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    // Result bits enter at the MSB so bit i settles in MAG[i].
                    MAG     <= {w_bit, MAG[width-1:1]};
                    r_shreg <= {1'b0, r_shreg[width-1:1]};
                    r_cnt   <= r_cnt + cntw'(1);
                    if (r_cnt == LAST)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    if (OUT_READY)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_abs.sv
// Self-checking bench for serial_abs: directed scenarios plus randomized sweeps.
module tb_serial_abs;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // width = 8 instance
    logic       IV8 = 0, IR8, OV8, OR8 = 0, SG8, MN8;
    logic [7:0] IN8 = 0, MAG8;
    // width = 13 instance
    logic        IV13 = 0, IR13, OV13, OR13 = 0, SG13, MN13;
    logic [12:0] IN13 = 0, MAG13;
    // width = 2 instance
    logic       IV2 = 0, IR2, OV2, OR2 = 0, SG2, MN2;
    logic [1:0] IN2 = 0, MAG2;

    serial_abs #(.width(8)) u8 (
        .CLK(CLK), .RST(RST), .IN_VALID(IV8), .IN_READY(IR8), .IN(IN8),
        .OUT_VALID(OV8), .OUT_READY(OR8), .MAG(MAG8), .SIGN(SG8), .MINNEG(MN8));
    serial_abs #(.width(13)) u13 (
        .CLK(CLK), .RST(RST), .IN_VALID(IV13), .IN_READY(IR13), .IN(IN13),
        .OUT_VALID(OV13), .OUT_READY(OR13), .MAG(MAG13), .SIGN(SG13), .MINNEG(MN13));
    serial_abs #(.width(2)) u2 (
        .CLK(CLK), .RST(RST), .IN_VALID(IV2), .IN_READY(IR2), .IN(IN2),
        .OUT_VALID(OV2), .OUT_READY(OR2), .MAG(MAG2), .SIGN(SG2), .MINNEG(MN2));

    int checks = 0;
    int errors = 0;

    // Reference: |v| as an unsigned w-bit value.
    function automatic longint unsigned ref_mag(input longint unsigned v, input int w);
        longint unsigned m = 64'd1 << w;
        v = v % m;
        return (v >= m / 2) ? (m - v) % m : v;
    endfunction

    function automatic bit ref_sign(input longint unsigned v, input int w);
        return (v % (64'd1 << w)) >= (64'd1 << (w - 1));
    endfunction

    function automatic bit ref_minneg(input longint unsigned v, input int w);
        return (v % (64'd1 << w)) == (64'd1 << (w - 1));
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // One width-8 transaction; returns observations, comparisons done by callers.
    task automatic run8(input logic [7:0] v, input int hold, input bit rel,
                        output int lat, output logic [7:0] mag,
                        output logic sg, output logic mn, output bit busy_ok);
        busy_ok = 1;
        IN8 = v; IV8 = 1;
        tick;
        IV8 = 0; IN8 = 8'($urandom);
        lat = 1;
        while (!OV8 && lat < 40) begin
            if (IR8 !== 1'b0) busy_ok = 0;
            IN8 = 8'($urandom);
            tick;
            lat++;
        end
        repeat (hold) tick;
        mag = MAG8; sg = SG8; mn = MN8;
        if (rel) begin
            OR8 = 1; tick; OR8 = 0;
        end
    endtask

    task automatic test_reset;
        RST = 1; tick; tick; RST = 0;
        checks++;
        if ({IR8, OV8, MAG8, SG8, MN8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b mag=%h sign=%b mn=%b, want 1 0 00 0 0",
                     IR8, OV8, MAG8, SG8, MN8);
        end
        checks++;
        if (IR13 !== 1'b1 || OV13 !== 1'b0 || IR2 !== 1'b1 || OV2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_other_widths: ir13=%b ov13=%b ir2=%b ov2=%b", IR13, OV13, IR2, OV2);
        end
    endtask

    task automatic test_positive;
        IN8 = 8'h05; IV8 = 1;
        tick;
        IV8 = 0;
        checks++;
        if ({IR8, OV8, MAG8, SG8, MN8} !== {1'b0, 1'b1, 8'h05, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL positive: rdy=%b vld=%b mag=%h sign=%b mn=%b, want 0 1 05 0 0",
                     IR8, OV8, MAG8, SG8, MN8);
        end
        OR8 = 1; tick; OR8 = 0;
        checks++;
        if (IR8 !== 1'b1 || OV8 !== 1'b0) begin
            errors++;
            $display("FAIL positive_release: rdy=%b vld=%b, want 1 0", IR8, OV8);
        end
    endtask

    task automatic test_negative;
        int lat; logic [7:0] m; logic s, n; bit b;
        run8(8'hFB, 0, 1, lat, m, s, n, b);
        checks++;
        if (lat != 9 || m !== 8'h05 || s !== 1'b1 || n !== 1'b0 || !b) begin
            errors++;
            $display("FAIL negative: lat=%0d mag=%h sign=%b mn=%b busy_ok=%0d, want 9 05 1 0 1",
                     lat, m, s, n, b);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] vin [3] = '{8'h80, 8'hFF, 8'h00};
        logic [7:0] em  [3] = '{8'h80, 8'h01, 8'h00};
        logic       es  [3] = '{1'b1, 1'b1, 1'b0};
        logic       en  [3] = '{1'b1, 1'b0, 1'b0};
        int         el  [3] = '{9, 9, 1};
        int lat; logic [7:0] m; logic s, n; bit b;
        for (int i = 0; i < 3; i++) begin
            run8(vin[i], 0, 1, lat, m, s, n, b);
            checks++;
            if (lat != el[i] || m !== em[i] || s !== es[i] || n !== en[i]) begin
                errors++;
                $display("FAIL b2b[%0d] in=%h: lat=%0d mag=%h sign=%b mn=%b, want %0d %h %b %b",
                         i, vin[i], lat, m, s, n, el[i], em[i], es[i], en[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        int lat; logic [7:0] m; logic s, n; bit b;
        bit stable = 1;
        run8(8'hC6, 0, 0, lat, m, s, n, b);
        for (int i = 0; i < 5; i++) begin
            IV8 = 1; IN8 = (i % 2) ? 8'h11 : 8'hEE;
            tick;
            if (MAG8 !== 8'h3A || SG8 !== 1'b1 || OV8 !== 1'b1 || IR8 !== 1'b0) stable = 0;
        end
        checks++;
        if (!stable || m !== 8'h3A) begin
            errors++;
            $display("FAIL hold: stable=%0d mag=%h, want 1 3a", stable, MAG8);
        end
        IN8 = 8'h11; OR8 = 1;
        tick;
        OR8 = 0;
        checks++;
        if (IR8 !== 1'b1 || OV8 !== 1'b0 || MAG8 !== 8'h3A) begin
            errors++;
            $display("FAIL hold_release: rdy=%b vld=%b mag=%h, want 1 0 3a", IR8, OV8, MAG8);
        end
        tick;
        IV8 = 0;
        checks++;
        if (OV8 !== 1'b1 || MAG8 !== 8'h11 || SG8 !== 1'b0) begin
            errors++;
            $display("FAIL hold_next_accept: vld=%b mag=%h sign=%b, want 1 11 0", OV8, MAG8, SG8);
        end
        OR8 = 1; tick; OR8 = 0;
    endtask

    task automatic test_reset_mid_shift;
        int lat; logic [7:0] m; logic s, n; bit b;
        IN8 = 8'h9C; IV8 = 1;
        tick;
        IV8 = 0;
        tick; tick;
        RST = 1;
        tick;
        RST = 0;
        checks++;
        if ({IR8, OV8, MAG8, SG8, MN8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b vld=%b mag=%h sign=%b mn=%b, want 1 0 00 0 0",
                     IR8, OV8, MAG8, SG8, MN8);
        end
        run8(8'h9C, 0, 1, lat, m, s, n, b);
        checks++;
        if (lat != 9 || m !== 8'h64 || s !== 1'b1 || n !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: lat=%0d mag=%h sign=%b mn=%b, want 9 64 1 0", lat, m, s, n);
        end
    endtask

    task automatic test_sweep8;
        int lat; logic [7:0] m; logic s, n; bit b;
        int bad = 0;
        int off = int'($urandom_range(0, 255));
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v = 8'((i * 37 + off) & 255);
            int el = ref_sign(v, 8) ? 9 : 1;
            run8(v, int'($urandom_range(0, 3)), 1, lat, m, s, n, b);
            repeat ($urandom_range(0, 1)) tick;
            checks++;
            if (lat != el || m !== 8'(ref_mag(v, 8)) || s !== ref_sign(v, 8) ||
                n !== ref_minneg(v, 8) || !b) begin
                errors++;
                if (bad++ < 8)
                    $display("FAIL sweep8 in=%h: lat=%0d mag=%h sign=%b mn=%b, want %0d %h %b %b",
                             v, lat, m, s, n, el, 8'(ref_mag(v, 8)), ref_sign(v, 8), ref_minneg(v, 8));
            end
        end
    endtask

    task automatic test_width13;
        logic [12:0] v;
        int lat, bad = 0;
        for (int i = 0; i < 40; i++) begin
            v = (i == 0) ? 13'h1000 : (i == 1) ? 13'h1FFF : (i == 2) ? 13'h0000 : 13'($urandom);
            IN13 = v; IV13 = 1;
            tick;
            IV13 = 0; IN13 = 13'($urandom);
            lat = 1;
            while (!OV13 && lat < 40) begin tick; lat++; end
            repeat ($urandom_range(0, 2)) tick;
            checks++;
            if (lat != (ref_sign(v, 13) ? 14 : 1) || MAG13 !== 13'(ref_mag(v, 13)) ||
                SG13 !== ref_sign(v, 13) || MN13 !== ref_minneg(v, 13)) begin
                errors++;
                if (bad++ < 8)
                    $display("FAIL w13 in=%h: lat=%0d mag=%h sign=%b mn=%b, want mag %h",
                             v, lat, MAG13, SG13, MN13, 13'(ref_mag(v, 13)));
            end
            OR13 = 1; tick; OR13 = 0;
        end
    endtask

    task automatic test_width2;
        logic [1:0] v;
        int lat;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            IN2 = v; IV2 = 1;
            tick;
            IV2 = 0;
            lat = 1;
            while (!OV2 && lat < 20) begin tick; lat++; end
            checks++;
            if (lat != (ref_sign(v, 2) ? 3 : 1) || MAG2 !== 2'(ref_mag(v, 2)) ||
                SG2 !== ref_sign(v, 2) || MN2 !== ref_minneg(v, 2)) begin
                errors++;
                $display("FAIL w2 in=%b: lat=%0d mag=%b sign=%b mn=%b, want %b %b %b",
                         v, lat, MAG2, SG2, MN2, 2'(ref_mag(v, 2)), ref_sign(v, 2), ref_minneg(v, 2));
            end
            OR2 = 1; tick; OR2 = 0;
        end
    endtask

    initial begin
        test_reset;
        test_positive;
        test_negative;
        test_back_to_back;
        test_backpressure;
        test_reset_mid_shift;
        test_sweep8;
        test_width13;
        test_width2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
